fft_frame_sched: RTL and testbench

Sliding-window frame scheduler that shares one CFFT core between the LED1 and LED2 channels of the pulse-ox datapath. It decimates the front-end sample stream, keeps the last N decimated samples of each channel in circular RAMs, and streams overlapping frames into the FFT. Frames alternate between channels round-robin. It sits between the front-end data buffer and the cfft/postdatabuffer pair and replaces per-channel RAM shifting with pointer arithmetic.

---
 rtl/pulseox_pkg.sv | 18 +
 rtl/fft_frame_sched_if.sv | 22 ++
 rtl/fft_win_ram.sv | 20 ++
 rtl/fft_frame_sched.sv | 147 ++++++++++++++
 tb/tb_fft_frame_sched.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pulseox_pkg.sv
// Shared types and defaults for the pulse-ox datapath.
// Holds the scheduler state encoding and the channel indices.
package pulseox_pkg;

    localparam int DATA_W     = 22;
    localparam int N_LOG2_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } sched_state_t;

    localparam logic CH_LED1 = 1'b0;
    localparam logic CH_LED2 = 1'b1;

endpackage

// File: rtl/fft_frame_sched_if.sv
// Frame bus between the scheduler and the CFFT / post data buffer.
// The scheduler is the master; the FFT side is the slave.
interface fft_frame_sched_if #(
    parameter int DATA_W = pulseox_pkg::DATA_W
);
    logic                     fft_start;
    logic signed [DATA_W-1:0] fft_iin;
    logic signed [DATA_W-1:0] fft_qin;
    logic                     fft_chan;
    logic                     fft_inputbusy;
    logic                     pdb_done;

    modport master (
        output fft_start, fft_iin, fft_qin, fft_chan,
        input  fft_inputbusy, pdb_done
    );

    modport slave (
        input  fft_start, fft_iin, fft_qin, fft_chan,
        output fft_inputbusy, pdb_done
    );
endinterface

// File: rtl/fft_win_ram.sv
// Simple dual-port window RAM, registered read-first read port.
// One instance holds the sliding window of one channel.
module fft_win_ram #(
    parameter int N_LOG2 = pulseox_pkg::N_LOG2_DEF,
    parameter int DATA_W = pulseox_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [N_LOG2-1:0]        wa,
    input  logic signed [DATA_W-1:0] wd,
    input  logic [N_LOG2-1:0]        ra,
    output logic signed [DATA_W-1:0] rd
);
    logic signed [DATA_W-1:0] mem [2**N_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/fft_frame_sched.sv
// Sliding-window frame scheduler sharing one CFFT between LED1/LED2.
// Decimates, keeps N samples per channel, streams overlapping frames.
module fft_frame_sched
    import pulseox_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DATA_W = pulseox_pkg::DATA_W,
    parameter int DECIM  = 12,
    parameter int HOP    = 40
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] led1,
    input  logic signed [DATA_W-1:0] led2,
    input  logic                     in_new_samples,
    fft_frame_sched_if.master        fft,
    output logic                     sched_busy,
    output logic [1:0]               overrun
);
    localparam int N    = 1 << N_LOG2;
    localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2:0]   cnt_t;

    logic [DC_W-1:0]          dec_cnt;
    addr_t                    wr_ptr, base, idx, idx_nx, rd_addr;
    cnt_t                     fill, hop_cnt;
    logic [1:0]               req, clr;
    logic                     last_grant, grant, can_go;
    logic                     accept, fire, chan;
    sched_state_t             state, state_nx;
    logic signed [DATA_W-1:0] rd1, rd2;

    assign accept = in_new_samples &&
                    (dec_cnt == DC_W'(DECIM - 1));
    assign fire = accept &&
                  ((fill == cnt_t'(N - 1)) ||
                   ((fill == cnt_t'(N)) &&
                    (hop_cnt == cnt_t'(HOP - 1))));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dec_cnt <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            hop_cnt <= '0;
        end else if (in_new_samples) begin
            dec_cnt <= accept ? '0 : dec_cnt + 1'b1;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != cnt_t'(N))
                    fill <= fill + 1'b1;
                else if (hop_cnt == cnt_t'(HOP - 1))
                    hop_cnt <= '0;
                else
                    hop_cnt <= hop_cnt + 1'b1;
            end
        end
    end

    // Round-robin only matters when both channels are pending.
    assign grant  = (&req) ? ~last_grant
                  : (req[CH_LED2] ? CH_LED2 : CH_LED1);
    assign can_go = (state == IDLE) && (|req) &&
                    !fft.fft_inputbusy;
    assign clr    = !can_go ? 2'b00
                  : (grant ? 2'b10 : 2'b01);

    // A new request beats a same-cycle grant clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req        <= '0;
            overrun    <= '0;
            last_grant <= 1'b1;
            chan       <= 1'b0;
            base       <= '0;
        end else begin
            req     <= fire ? 2'b11 : (req & ~clr);
            overrun <= fire ? (req & ~clr) : 2'b00;
            if (can_go) begin
                last_grant <= grant;
                chan       <= grant;
                base       <= wr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rd_addr  = base;
        unique case (state)
            IDLE:
                if (can_go) state_nx = START;
            START: begin
                state_nx = STREAM;
                idx_nx   = '0;
            end
            STREAM: begin
                rd_addr = base + idx + 1'b1;
                idx_nx  = idx + 1'b1;
                if (idx == addr_t'(N - 1))
                    state_nx = WAIT_DONE;
            end
            WAIT_DONE:
                if (fft.pdb_done) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    fft_win_ram #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) u_ram1 (
        .clk (clk),
        .we  (accept),
        .wa  (wr_ptr),
        .wd  (led1),
        .ra  (rd_addr),
        .rd  (rd1)
    );

    fft_win_ram #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) u_ram2 (
        .clk (clk),
        .we  (accept),
        .wa  (wr_ptr),
        .wd  (led2),
        .ra  (rd_addr),
        .rd  (rd2)
    );

    assign fft.fft_start = (state == START);
    assign fft.fft_iin   = (state != STREAM) ? '0
                         : (chan ? rd2 : rd1);
    assign fft.fft_qin   = '0;
    assign fft.fft_chan  = chan;
    assign sched_busy    = (state != IDLE);
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with N=8, DECIM=2, HOP=4.
// Expected frames are hand-derived from the strobe values.
module tb_fft_frame_sched;
    localparam int NL  = 3;
    localparam int DW  = 22;
    localparam int DEC = 2;
    localparam int HP  = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_new_samples = 1'b0;
    logic signed [DW-1:0] led1 = '0;
    logic signed [DW-1:0] led2 = '0;
    logic                 sched_busy;
    logic [1:0]           overrun;

    int n_chk = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_ov0 = 0;
    int n_ov1 = 0;
    int lat;

    fft_frame_sched_if #(.DATA_W(DW)) fi ();

    fft_frame_sched #(
        .N_LOG2 (NL),
        .DATA_W (DW),
        .DECIM  (DEC),
        .HOP    (HP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .led1           (led1),
        .led2           (led2),
        .in_new_samples (in_new_samples),
        .fft            (fi),
        .sched_busy     (sched_busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_start += int'(fi.fft_start === 1'b1);
        n_ov0   += int'(overrun[0] === 1'b1);
        n_ov1   += int'(overrun[1] === 1'b1);
    endtask

    task automatic strobe(input int v);
        led1 = DW'(v);
        led2 = DW'(100 + v);
        in_new_samples = 1'b1;
        tick();
        in_new_samples = 1'b0;
    endtask

    task automatic wait_start(output int l);
        l = 0;
        while (fi.fft_start !== 1'b1 && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic check_frame(input string tag,
                               input int first);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk(tag, 32'(fi.fft_iin), first + 2 * i);
        end
        chk({tag, "_qin"}, 32'(fi.fft_qin), 0);
    endtask

    task automatic pulse_done();
        fi.pdb_done = 1'b1;
        tick();
        fi.pdb_done = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fi.fft_inputbusy = 1'b0;
        fi.pdb_done = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_start", 32'(fi.fft_start), 0);
        chk("rst_iin", 32'(fi.fft_iin), 0);
        chk("rst_qin", 32'(fi.fft_qin), 0);
        chk("rst_chan", 32'(fi.fft_chan), 0);
        chk("rst_busy", 32'(sched_busy), 0);
        chk("rst_ovr", 32'(overrun), 0);

        // fill: odd strobes are kept
        n_start = 0;
        for (int k = 0; k < 15; k++) strobe(k);
        chk("fill_early", n_start, 0);
        strobe(15);
        wait_start(lat);
        chk("fill_lat", lat, 1);
        chk("fill_chan", 32'(fi.fft_chan), 0);
        chk("fill_busy", 32'(sched_busy), 1);
        check_frame("led1_fill", 1);
        tick();
        chk("wait_iin", 32'(fi.fft_iin), 0);
        chk("wait_busy", 32'(sched_busy), 1);

        // round-robin: LED2 follows
        pulse_done();
        wait_start(lat);
        chk("rr_lat", lat, 1);
        chk("rr_chan", 32'(fi.fft_chan), 1);
        check_frame("led2_fill", 101);
        tick();
        pulse_done();
        tick();
        chk("rr_idle", 32'(sched_busy), 0);

        // hop: window wraps, oldest first
        for (int k = 16; k < 24; k++) strobe(k);
        wait_start(lat);
        chk("hop_lat", lat, 1);
        chk("hop_chan", 32'(fi.fft_chan), 0);
        check_frame("led1_hop", 9);
        tick();

        // busy gating with LED2 pending
        fi.fft_inputbusy = 1'b1;
        pulse_done();
        n_start = 0;
        repeat (5) tick();
        chk("busy_gate", n_start, 0);
        chk("busy_idle", 32'(sched_busy), 0);
        fi.fft_inputbusy = 1'b0;
        tick();
        chk("busy_release", 32'(fi.fft_start), 1);
        chk("busy_chan", 32'(fi.fft_chan), 1);
        check_frame("led2_hop", 109);
        tick();

        // overrun: two hops without pdb_done
        n_start = 0;
        n_ov0 = 0;
        n_ov1 = 0;
        for (int k = 24; k < 40; k++) strobe(k);
        tick();
        chk("ovr1_cnt", n_ov1, 1);
        chk("ovr0_cnt", n_ov0, 1);
        chk("ovr_nostart", n_start, 0);
        chk("ovr_busy", 32'(sched_busy), 1);

        // next frame, reset at idx=3
        pulse_done();
        wait_start(lat);
        chk("post_lat", lat, 1);
        chk("post_chan", 32'(fi.fft_chan), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_iin", 32'(fi.fft_iin), 25 + 2 * i);
        end
        reset_n = 1'b0;
        tick();
        chk("abort_iin", 32'(fi.fft_iin), 0);
        chk("abort_start", 32'(fi.fft_start), 0);
        chk("abort_busy", 32'(sched_busy), 0);
        chk("abort_ovr", 32'(overrun), 0);
        reset_n = 1'b1;

        // refill needs a full 16 strobes
        n_start = 0;
        for (int k = 0; k < 15; k++) strobe(200 + k);
        chk("refill_early", n_start, 0);
        strobe(215);
        wait_start(lat);
        chk("refill_lat", lat, 1);
        chk("refill_chan", 32'(fi.fft_chan), 0);
        check_frame("led1_refill", 201);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
